// File: rtl/hub75_bcm_driver.sv
// HUB75 single-chain driver with binary-coded modulation: bit-plane p is lit for
// (BASE_TICKS<<p) cycles scaled by brightness, while the next plane shifts in.
module hub75_bcm_driver #(
  parameter int COLOR_BITS    = 4,
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int COLOR_COUNT   = 3,
  parameter int BASE_TICKS    = 160
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [7:0]                                        brightness,
  input  logic [(2**COL_ADDR_BITS)*COLOR_COUNT*COLOR_BITS-1:0] row_in,
  input  logic                                              row_valid,
  output logic                                              row_req,
  output logic [ROW_ADDR_BITS-1:0]                          row_addr,
  output logic                                              hub_clk,
  output logic                                              hub_lat,
  output logic                                              hub_noe,
  output logic [ROW_ADDR_BITS-1:0]                          hub_mux,
  output logic [COLOR_COUNT-1:0]                            s_out,
  output logic                                              frame_start
);

  localparam int NUM_COL  = 2**COL_ADDR_BITS;
  localparam int ROW_W    = NUM_COL*COLOR_COUNT*COLOR_BITS;
  localparam int IDX_W    = $clog2(ROW_W);
  localparam int MAX_SLOT = BASE_TICKS << (COLOR_BITS-1);
  localparam int SLOT_W   = $clog2(MAX_SLOT+1);
  localparam int PLANE_W  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOR_BITS-1);

  typedef enum logic [1:0] {SH_WAIT_ROW, SH_SHIFT, SH_DONE} sh_state_t;
  typedef enum logic [1:0] {DISP, BLANK, LATCH, UNBLANK}     disp_state_t;

  sh_state_t   sh_state, sh_next;
  disp_state_t disp_state, disp_next;

  logic                     started;
  logic [ROW_W-1:0]         row_buf;
  logic                     buf_full;
  logic [ROW_ADDR_BITS-1:0] buf_row;
  logic                     phase;
  logic [COL_ADDR_BITS-1:0] col;
  logic [PLANE_W-1:0]       sh_plane;
  logic [PLANE_W-1:0]       lit_plane;
  logic [SLOT_W-1:0]        slot_cnt, slot_len, on_len, slot_len_nxt;
  logic [SLOT_W+7:0]        on_prod;
  logic                     capture, shift_last, slot_expired;

  assign capture      = row_req & row_valid;
  assign shift_last   = (sh_state == SH_SHIFT) && phase && (col == '0) && (sh_plane == LAST_PLANE);
  assign slot_expired = ({1'b0, slot_cnt} + 1'b1) >= {1'b0, slot_len};
  assign slot_len_nxt = SLOT_W'(BASE_TICKS) << lit_plane;
  assign on_prod      = {8'd0, slot_len_nxt} * {{SLOT_W{1'b0}}, brightness};

  // Fetch: one request after reset, then one per row once the last plane is shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      row_req  <= 1'b0;
      row_addr <= '0;
      buf_full <= 1'b0;
      buf_row  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      started <= 1'b1;
      if (!started) begin
        row_req <= 1'b1;
      end else if (shift_last) begin
        row_req  <= 1'b1;
        row_addr <= row_addr + 1'b1;
      end else if (capture) begin
        row_req <= 1'b0;
      end
      if (capture) begin
        buf_full <= 1'b1;
        buf_row  <= row_addr;
      end else if (shift_last) begin
        buf_full <= 1'b0;
      end
    end
  end

  // NOTE: the row buffer is plain storage with no reset; its contents are only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) row_buf <= row_in;
  end

  // Shifter FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_state <= SH_WAIT_ROW;
    else     sh_state <= sh_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns sh_next and no latch is inferred.
    sh_next = sh_state;
    case (sh_state)
      SH_WAIT_ROW: if (buf_full) sh_next = SH_SHIFT;
      SH_SHIFT:    if (phase && col == '0) sh_next = SH_DONE;
      SH_DONE:     if (disp_state == LATCH)
                     sh_next = (sh_plane == LAST_PLANE) ? SH_WAIT_ROW : SH_SHIFT;
      default:     sh_next = SH_WAIT_ROW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      col      <= '1;
      sh_plane <= '0;
    end else begin
      if (sh_state == SH_SHIFT) begin
        phase <= ~phase;
        if (phase) col <= col - 1'b1;
      end
      if (sh_state == SH_DONE && disp_state == LATCH)
        sh_plane <= (sh_plane == LAST_PLANE) ? '0 : sh_plane + 1'b1;
    end
  end

  // Display FSM; slot_len=0 out of reset keeps the panel dark until the first latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_state <= DISP;
    else     disp_state <= disp_next;
  end

  always_comb begin
    disp_next = disp_state;
    case (disp_state)
      DISP:    if (slot_expired && sh_state == SH_DONE) disp_next = BLANK;
      BLANK:   disp_next = LATCH;
      LATCH:   disp_next = UNBLANK;
      UNBLANK: disp_next = DISP;
      default: disp_next = DISP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      slot_len  <= '0;
      on_len    <= '0;
      lit_plane <= '0;
      hub_mux   <= '0;
    end else begin
      case (disp_state)
        UNBLANK: begin
          slot_len <= slot_len_nxt;
          on_len   <= on_prod[SLOT_W+7:8];
          slot_cnt <= '0;
        end
        DISP:    if (slot_cnt != slot_len) slot_cnt <= slot_cnt + 1'b1;
        BLANK:   if (sh_plane == '0) hub_mux <= buf_row;
        LATCH:   lit_plane <= sh_plane;
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    hub_clk     = (sh_state == SH_SHIFT) && phase;
    hub_lat     = (disp_state == LATCH);
    hub_noe     = !((disp_state == DISP) && (slot_cnt < on_len));
    frame_start = (disp_state == LATCH) && (sh_plane == '0) && (hub_mux == '0);
    s_out       = '0;
    for (int c = 0; c < COLOR_COUNT; c++) begin
      s_out[c] = (sh_state == SH_SHIFT) &&
                 row_buf[IDX_W'((int'(col)*COLOR_COUNT + c)*COLOR_BITS + int'(sh_plane))];
    end
  end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
- Parametrised successor to the current HUB75 panel scan logic.
- Drives one HUB75 chain with true binary-coded modulation: bit-plane p gets BASE_TICKS<<p on-time, scaled by a global brightness input.
- Fetches one row at a time from the frame-buffer RAM over a req/valid handshake.
- Shifts the next bit-plane while the current one is lit; blanks only around latch and row-address changes.

Parameters:
- COLOR_BITS, 4, bits per colour channel (number of bit-planes), >=1
- COL_ADDR_BITS, 6, NUM_COL = 2**COL_ADDR_BITS pixels per row
- ROW_ADDR_BITS, 4, scan rows = 2**ROW_ADDR_BITS
- COLOR_COUNT, 3, channels per pixel (serial data outputs)
- BASE_TICKS, 160, clk cycles in the plane-0 display slot

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- brightness  in  8  global dimming; sampled at each slot start
- row_in  in  NUM_COL*COLOR_COUNT*COLOR_BITS  row data; pixel i, channel c, bit b at ((i*COLOR_COUNT)+c)*COLOR_BITS+b
- row_valid  in  1  row_in valid for row_addr
- row_req  out  1  request for row row_addr
- row_addr  out  ROW_ADDR_BITS  row being requested
- hub_clk  out  1  panel shift clock
- hub_lat  out  1  panel latch, active high
- hub_noe  out  1  panel output enable, active low
- hub_mux  out  ROW_ADDR_BITS  panel row select
- s_out  out  COLOR_COUNT  serial pixel data, one bit per channel
- frame_start  out  1  one-cycle pulse when row 0 plane 0 is latched

Behaviour:
- Reset (async, any state) values: hub_clk=0, hub_lat=0, hub_noe=1, hub_mux=0, s_out=0, row_req=0, row_addr=0, frame_start=0. The internal row buffer contents are don't-care. The first cycle after release asserts row_req with row_addr=0.
- Fetch:
  - row_req stays high until a cycle with row_valid=1. In that cycle row_in is captured into a single internal row buffer, and row_req drops the next cycle.
  - row_valid while row_req=0 is ignored.
  - The next request is issued the cycle after shifting of plane COLOR_BITS-1 completes. The buffer is free then. row_addr increments mod 2**ROW_ADDR_BITS, wrapping 15->0.
- Shifter FSM (SH_WAIT_ROW, SH_SHIFT, SH_DONE):
  - Each column takes 2 clk cycles. In cycle A, s_out[c] is set to bit p of the column's channel c and hub_clk=0. In cycle B, hub_clk=1.
  - Column NUM_COL-1 is shifted first and column 0 last. One plane takes 2*NUM_COL cycles.
  - SH_DONE holds with hub_clk=0 until the latch. Planes run 0..COLOR_BITS-1, then the next row's plane 0.
  - Plane 0 waits in SH_WAIT_ROW until the buffer is filled.
- Display FSM (DISP, BLANK, LATCH, UNBLANK):
  - DISP counts a slot of BASE_TICKS<<p cycles for the lit plane p.
  - hub_noe=0 while slot_cnt < (slot_len*brightness)>>8, else 1. Use full-width arithmetic with no overflow. brightness=0 keeps the display dark.
  - When the slot expires and the shifter is in SH_DONE: BLANK (hub_noe=1) for 1 cycle, then LATCH (hub_lat=1) for 1 cycle, then UNBLANK, which starts the slot for the newly latched plane.
  - If the slot expires before SH_DONE: hub_noe=1 while waiting, and the latch occurs when SH_DONE is reached.
  - If the shift finishes before slot expiry: wait, with no early latch.
  - In LATCH of a plane-0 shift, hub_mux is updated to that row. frame_start pulses in that cycle if the row is 0.
  - The shifter restarts the cycle after LATCH.
- Start-up: no DISP before the first latch; hub_noe=1 until the first UNBLANK.
- Simultaneous events:
  - A row_valid arriving in the same cycle as LATCH is captured normally.
  - A brightness change takes effect only at the next slot start.

Test Plan:
- Reset release, row_valid tied high -> row_req=1/row_addr=0 on cycle 1. After 128 shift cycles: BLANK, then hub_lat=1 for one cycle, hub_mux=0, frame_start=1.
- Pixel 63 R=4'b0001, all others 0; brightness=255 -> plane-0 shift gives s_out[0]=1 on the first hub_clk rising edge only. Planes 1-3 give all zeros.
- brightness=255 -> hub_noe low for 159, 318, 637, 1275 cycles in plane slots 0..3. brightness=128 gives 80, 160, 320, 640. brightness=0 keeps hub_noe=1 throughout.
- row_valid delayed 500 cycles after row_req -> plane-0 latch is held off and hub_noe=1 while waiting. hub_mux changes only at that latch.
- Run 16 rows -> row_addr/hub_mux wrap 15->0, with frame_start pulsing once per frame.
- Assert rst mid-shift and mid-DISP -> outputs take reset values immediately (async). The sequence restarts from row 0 plane 0.
